// File: rtl/data_memory_hs_if.sv
// Request/response bus of data_memory_hs: valid/ready request channel plus a one-cycle response strobe.
interface data_memory_hs_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );
endinterface

// File: rtl/data_memory_hs.sv
// Byte-addressed RV32I data memory with wait states; define DMEM_MISALIGN_TRAP_EN to fault misaligned
// half/word accesses instead of forcing their low address bits to zero.
module data_memory_hs #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic           clk,
  input logic           rst,
  data_memory_hs_if.slave bus
);
  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, uns_q;
  logic [1:0]      size_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            req_ready_q, rsp_valid_q, rsp_fault_q, busy_q;
  logic [31:0]     rsp_rdata_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept, do_access, wr_en, fault, misalign;
  logic            e_we, e_uns;
  logic [1:0]      e_size, off;
  logic [AW+1:0]   e_addr;
  logic [31:0]     e_wdata, word_rd, sh, ld, rd_d, wlane;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:AW+2];

  always_comb begin
    accept  = (state_q != S_WAIT) && bus.req_valid && !rst;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // With zero wait states the access happens on the acceptance edge, so the live inputs are used.
    e_we    = accept ? bus.req_we           : we_q;
    e_size  = accept ? bus.req_size         : size_q;
    e_uns   = accept ? bus.req_unsigned     : uns_q;
    e_addr  = accept ? bus.req_addr[AW+1:0] : addr_q;
    e_wdata = accept ? bus.req_wdata        : wdata_q;

    idx = e_addr[AW+1:2];
    case (e_size)
      2'd1:    off = {e_addr[1], 1'b0};
      2'd2:    off = 2'b00;
      default: off = e_addr[1:0];
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((e_size == 2'd1) && e_addr[0]) || ((e_size == 2'd2) && (e_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    fault = (e_size == 2'd3) || misalign;

    case (e_size)
      2'd0:    begin be = 4'b0001 << off;                      wlane = {4{e_wdata[7:0]}};  end
      2'd1:    begin be = off[1] ? 4'b1100 : 4'b0011;          wlane = {2{e_wdata[15:0]}}; end
      2'd2:    begin be = 4'b1111;                             wlane = e_wdata;            end
      default: begin be = 4'b0000;                             wlane = '0;                 end
    endcase

    word_rd = mem[idx];
    sh      = word_rd >> {off, 3'b000};
    case (e_size)
      2'd0:    ld = e_uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    ld = e_uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ld = word_rd;
    endcase
    rd_d = (e_we || fault) ? '0 : ld;

    do_access = (state_d == S_RESP);
    wr_en     = do_access && e_we && !fault;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        addr_q  <= bus.req_addr[AW+1:0];
        wdata_q <= bus.req_wdata;
      end
      req_ready_q <= (state_d != S_WAIT);
      rsp_valid_q <= (state_d == S_RESP);
      busy_q      <= (state_d != S_IDLE);
      if (do_access) begin
        rsp_rdata_q <= rd_d;
        rsp_fault_q <= fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_data_memory_hs.sv
// Scoreboard bench for data_memory_hs: one instance with one wait state, one with none.
module tb_data_memory_hs;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_memory_hs_if if1 ();
  data_memory_hs_if if0 ();

  data_memory_hs #(.DEPTH_WORDS(512), .WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  data_memory_hs #(.DEPTH_WORDS(512), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit MF = 1'b1;
`else
  localparam bit MF = 1'b0;
`endif

  typedef struct { logic [31:0] rdata; logic fault; } exp_t;
  typedef struct { logic we; logic [1:0] size; logic uns; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp; logic efault; } op_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] bmem [2048];

  // Reference byte-array model of one access (wraps at 4*512 bytes).
  function automatic void model_acc(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic [31:0] rdata, output logic fault);
    logic [10:0] a;
    int unsigned n;
    logic [31:0] v;
    a = addr[10:0];
    rdata = '0;
    fault = (size == 2'd3);
    if (MF) begin
      if ((size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'b00)) fault = 1'b1;
    end else begin
      if (size == 2'd1) a[0] = 1'b0;
      if (size == 2'd2) a[1:0] = 2'b00;
    end
    if (fault) return;
    n = 1 << size;
    if (we) begin
      for (int unsigned i = 0; i < n; i++) bmem[a + 11'(i)] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = bmem[a + 11'(i)];
      if (!uns && n < 4) for (int unsigned j = 8*n; j < 32; j++) v[j] = v[8*n-1];
      rdata = v;
    end
  endfunction

  // Issues one request to the one-wait-state instance and returns what came back.
  task automatic drive1(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output logic fault, output logic busy_w, output logic ok);
    ok = 1'b0; lat = 0; rdata = '0; fault = 1'b0; busy_w = 1'b0;
    @(negedge clk);
    if1.req_valid = 1'b1; if1.req_we = we; if1.req_size = size; if1.req_unsigned = uns;
    if1.req_addr = addr; if1.req_wdata = wdata;
    for (int i = 0; i < 20 && !if1.req_ready; i++) @(negedge clk);
    if (!if1.req_ready) begin if1.req_valid = 1'b0; return; end
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0; if1.req_we = ~we; if1.req_size = ~size; if1.req_unsigned = ~uns;
    if1.req_addr = ~addr; if1.req_wdata = ~wdata;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) busy_w = if1.busy;
      if (if1.rsp_valid) begin
        lat = i; rdata = if1.rsp_rdata; fault = if1.rsp_fault; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if1.req_valid = 0; if1.req_we = 0; if1.req_size = 0; if1.req_unsigned = 0; if1.req_addr = 0; if1.req_wdata = 0;
    if0.req_valid = 0; if0.req_we = 0; if0.req_size = 0; if0.req_unsigned = 0; if0.req_addr = 0; if0.req_wdata = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (if1.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", if1.req_ready); end
    n_checks++; if (if1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", if1.rsp_valid); end
    n_checks++; if (if1.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", if1.rsp_rdata); end
    n_checks++; if (if1.rsp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", if1.rsp_fault); end
    n_checks++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", if1.busy); end
    n_checks++; if ({if0.req_ready, if0.rsp_valid, if0.busy} !== 3'b100) begin n_fail++; $display("FAIL reset_dut0: got %b expected 100", {if0.req_ready, if0.rsp_valid, if0.busy}); end
  endtask

  task automatic test_loads;
    op_t ops[10];
    int lat; logic [31:0] rd; logic f, b, ok; exp_t e;
    ops[0] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    ops[1] = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0};
    ops[2] = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0};
    ops[3] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0};
    ops[4] = '{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF5A, 32'h0, 1'b0};
    ops[5] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h00005A00, 1'b0};
    ops[6] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001, 32'h0, 1'b0};
    ops[7] = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFF8001, 1'b0};
    ops[8] = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h00008001, 1'b0};
    ops[9] = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0};
    foreach (ops[i]) begin
      sb.push_back('{ops[i].exp, ops[i].efault});
      drive1(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, lat, rd, f, b, ok);
      e = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL loads_timeout[%0d]: no response expected within 20 cycles", i); continue; end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL loads_latency[%0d]: got %0d expected 2", i, lat); end
      n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL loads_busy[%0d]: got %b expected 1", i, b); end
      n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL loads_rdata[%0d]: got %h expected %h", i, rd, e.rdata); end
      n_checks++; if (f !== e.fault) begin n_fail++; $display("FAIL loads_fault[%0d]: got %b expected %b", i, f, e.fault); end
    end
  endtask

  task automatic test_misalign;
    op_t ops[7];
    int lat; logic [31:0] rd; logic f, b, ok; exp_t e;
    ops[0] = '{1'b1, 2'd2, 1'b0, 32'h20, 32'hAAAA5555, 32'h0, 1'b0};
    ops[1] = '{1'b1, 2'd2, 1'b0, 32'h22, 32'hCAFEF00D, 32'h0, MF};
    ops[2] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, MF ? 32'hAAAA5555 : 32'hCAFEF00D, 1'b0};
    ops[3] = '{1'b0, 2'd1, 1'b1, 32'h21, 32'h0, MF ? 32'h0 : 32'h0000F00D, MF};
    ops[4] = '{1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1};
    ops[5] = '{1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1};
    ops[6] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, MF ? 32'hAAAA5555 : 32'hCAFEF00D, 1'b0};
    foreach (ops[i]) begin
      sb.push_back('{ops[i].exp, ops[i].efault});
      drive1(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, lat, rd, f, b, ok);
      e = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL misalign_timeout[%0d]: no response expected within 20 cycles", i); continue; end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL misalign_latency[%0d]: got %0d expected 2", i, lat); end
      n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL misalign_rdata[%0d]: got %h expected %h", i, rd, e.rdata); end
      n_checks++; if (f !== e.fault) begin n_fail++; $display("FAIL misalign_fault[%0d]: got %b expected %b", i, f, e.fault); end
    end
  endtask

  task automatic test_alias;
    op_t ops[5];
    int lat; logic [31:0] rd; logic f, b, ok; exp_t e;
    ops[0] = '{1'b1, 2'd2, 1'b0, 32'h800, 32'h13579BDF, 32'h0, 1'b0};
    ops[1] = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h13579BDF, 1'b0};
    ops[2] = '{1'b1, 2'd2, 1'b0, 32'h4, 32'h2468ACE0, 32'h0, 1'b0};
    ops[3] = '{1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 32'h2468ACE0, 1'b0};
    ops[4] = '{1'b0, 2'd2, 1'b0, 32'hFFFFF800, 32'h0, 32'h13579BDF, 1'b0};
    foreach (ops[i]) begin
      sb.push_back('{ops[i].exp, ops[i].efault});
      drive1(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, lat, rd, f, b, ok);
      e = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL alias_timeout[%0d]: no response expected within 20 cycles", i); continue; end
      n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL alias_rdata[%0d]: got %h expected %h", i, rd, e.rdata); end
      n_checks++; if (f !== e.fault) begin n_fail++; $display("FAIL alias_fault[%0d]: got %b expected %b", i, f, e.fault); end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_size = 2'd2; if0.req_unsigned = 1'b0;
    if0.req_addr = 32'h20; if0.req_wdata = 32'h12345678;
    sb.push_back('{32'h0, 1'b0});
    sb.push_back('{32'h12345678, 1'b0});
    n_checks++; if (if0.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle: got %b expected 1", if0.req_ready); end
    @(posedge clk);
    #1;
    if0.req_we = 1'b0; if0.req_wdata = 32'h0;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++; if (if0.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_store_valid: got %b expected 1", if0.rsp_valid); end
    n_checks++; if (if0.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_resp1: got %b expected 1", if0.req_ready); end
    n_checks++; if (if0.rsp_rdata !== e.rdata) begin n_fail++; $display("FAIL b2b_store_rdata: got %h expected %h", if0.rsp_rdata, e.rdata); end
    @(posedge clk);
    #1;
    if0.req_valid = 1'b0; if0.req_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++; if (if0.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_load_valid: got %b expected 1", if0.rsp_valid); end
    n_checks++; if (if0.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_resp2: got %b expected 1", if0.req_ready); end
    n_checks++; if (if0.rsp_rdata !== e.rdata) begin n_fail++; $display("FAIL b2b_load_rdata: got %h expected %h", if0.rsp_rdata, e.rdata); end
    n_checks++; if (if0.rsp_fault !== e.fault) begin n_fail++; $display("FAIL b2b_load_fault: got %b expected %b", if0.rsp_fault, e.fault); end
    @(negedge clk);
    n_checks++; if ({if0.rsp_valid, if0.busy} !== 2'b00) begin n_fail++; $display("FAIL b2b_strobe_end: got %b expected 00", {if0.rsp_valid, if0.busy}); end
    n_checks++; if (if0.rsp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL b2b_rdata_hold: got %h expected 12345678", if0.rsp_rdata); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic f, b, ok; exp_t e;
    int seen;
    sb.push_back('{32'h0, 1'b0});
    drive1(1'b1, 2'd2, 1'b0, 32'h30, 32'h11112222, lat, rd, f, b, ok);
    e = sb.pop_front();
    n_checks++; if (!ok || rd !== e.rdata) begin n_fail++; $display("FAIL rstmid_prestore: ok %b got %h expected %h", ok, rd, e.rdata); end
    @(negedge clk);
    if1.req_valid = 1'b1; if1.req_we = 1'b1; if1.req_size = 2'd2; if1.req_addr = 32'h30; if1.req_wdata = 32'h0BADF00D;
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
    rst = 1'b1;
    seen = 0;
    repeat (3) begin @(negedge clk); if (if1.rsp_valid) seen++; end
    n_checks++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", if1.busy); end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (if1.rsp_valid) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_rsp: got %0d strobes expected 0", seen); end
    sb.push_back('{32'h11112222, 1'b0});
    drive1(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, lat, rd, f, b, ok);
    e = sb.pop_front();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: no response expected within 20 cycles"); end
    else begin
      n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL rstmid_word: got %h expected %h", rd, e.rdata); end
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd; logic f, b, ok; exp_t e;
    logic [31:0] er, addr, wd; logic ef, we, uns; logic [1:0] sz;
    for (int k = 0; k < 76; k++) begin
      if (k < 16) begin
        we = 1'b1; sz = 2'd2; uns = 1'b0; addr = 32'h100 + 32'(4*k); wd = $urandom;
      end else begin
        we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
        addr = 32'h100 + 32'($urandom_range(0, 63)); wd = $urandom;
      end
      model_acc(we, sz, uns, addr, wd, er, ef);
      sb.push_back('{er, ef});
      drive1(we, sz, uns, addr, wd, lat, rd, f, b, ok);
      e = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_timeout[%0d]: no response expected within 20 cycles", k); continue; end
      n_checks++; if (rd !== e.rdata || f !== e.fault || lat !== 2) begin
        n_fail++;
        $display("FAIL rand[%0d] we=%b sz=%0d u=%b a=%h: got %h/%b/lat%0d expected %h/%b/lat2", k, we, sz, uns, addr, rd, f, lat, e.rdata, e.fault);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loads();
    test_misalign();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
